// File: rtl/z80_bus_bridge_if.sv
// rtl/z80_bus_bridge_if.sv - Z80 pin strobes plus request/response handshake bundle
//
// Purpose: groups the CPU-side pins and the memory/IO model handshake of
// z80_bus_bridge into one bundle.
// Modports:
//   master - the bridge: reads CPU pins and model responses, drives D_out/D_oe,
//            nWAIT, req_* and timeout
//   slave  - the CPU core plus memory/IO model side (mirror of master)
interface z80_bus_bridge_if;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        nM1;
  logic        nMREQ;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        nRFSH;
  logic        nWAIT;
  logic        req_valid;
  logic        req_write;
  logic        req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_ack;
  logic [7:0]  rsp_rdata;
  logic        timeout;

  modport master (
    input  A, D_in, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, rsp_ack, rsp_rdata,
    output D_out, D_oe, nWAIT, req_valid, req_write, req_io, req_addr, req_wdata, timeout
  );

  modport slave (
    output A, D_in, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, rsp_ack, rsp_rdata,
    input  D_out, D_oe, nWAIT, req_valid, req_write, req_io, req_addr, req_wdata, timeout
  );
endinterface

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - Z80 pin strobes to one-shot valid/ack requests with nWAIT stretching
//
// Purpose: turns each Z80 memory/IO bus cycle into a single request held until
// the model acks, stretching the CPU via nWAIT meanwhile, then drives read data
// back until the CPU releases its strobes. Interrupt-acknowledge cycles are
// answered locally with INT_VECTOR and never reach the model.
// Ports:
//   CLK    in  clock shared with the CPU core
//   RESET  in  asynchronous reset, active-high
//   bus    z80_bus_bridge_if.master: A, D_in, nM1/nMREQ/nIORQ/nRD/nWR/nRFSH,
//          rsp_ack, rsp_rdata in; D_out, D_oe, nWAIT, req_valid, req_write,
//          req_io, req_addr, req_wdata, timeout out
// Parameters: INT_VECTOR (INTA byte), TIMEOUT (ack wait limit in cycles)
// Configuration macro: ZBUS_TIMEOUT_EN - when defined, a request left unacked
//   for TIMEOUT cycles completes with read data 8'hFF and a one-cycle timeout
//   pulse; when undefined the bridge waits indefinitely and timeout stays 0.
module z80_bus_bridge #(
  parameter logic [7:0]  INT_VECTOR = 8'hFF,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic              CLK,
  input logic              RESET,
  z80_bus_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    INTA = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT state;
  logic  activeQ;

  logic memRd, memWr, ioRd, ioWr, intAck;
  logic memCyc, active, start, strobesIdle;
  logic expire;

  always_comb begin
    memRd       = !bus.nMREQ && !bus.nRD && bus.nRFSH;
    memWr       = !bus.nMREQ && !bus.nWR;
    ioRd        = !bus.nIORQ && !bus.nRD && bus.nM1;
    ioWr        = !bus.nIORQ && !bus.nWR;
    intAck      = !bus.nIORQ && !bus.nM1;
    memCyc      = memRd || memWr;
    active      = memCyc || ioRd || ioWr || intAck;
    // A cycle starts only on an inactive->active transition between samples,
    // so strobes held across several clocks yield exactly one request.
    start       = active && !activeQ;
    // nMREQ is left out: the refresh half of an M1 cycle keeps it low.
    strobesIdle = bus.nRD && bus.nWR && bus.nIORQ;
  end

`ifdef ZBUS_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] waitCnt;

  // Counts edges spent in REQ; zero on entry, so expiry lands on the
  // TIMEOUT-th edge after req_valid rose.
  assign expire = (state == REQ) && (waitCnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      waitCnt <= '0;
    end else if (state != REQ) begin
      waitCnt <= '0;
    end else if (!expire) begin
      waitCnt <= waitCnt + CntW'(1);
    end
  end
`else
  logic [7:0] unusedTimeout;

  assign expire        = 1'b0;
  assign unusedTimeout = 8'(TIMEOUT);
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      // Starts high so strobes still asserted when reset drops are not
      // mistaken for a fresh cycle.
      activeQ       <= 1'b1;
      bus.nWAIT     <= 1'b1;
      bus.D_oe      <= 1'b0;
      bus.D_out     <= 8'h00;
      bus.req_valid <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_io    <= 1'b0;
      bus.req_addr  <= 16'h0000;
      bus.req_wdata <= 8'h00;
      bus.timeout   <= 1'b0;
    end else begin
      activeQ     <= active;
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // Priority: memory over INTA over IO.
            if (memCyc || !intAck) begin
              state         <= REQ;
              bus.req_valid <= 1'b1;
              bus.req_write <= memCyc ? memWr : ioWr;
              bus.req_io    <= !memCyc;
              bus.req_addr  <= bus.A;
              bus.req_wdata <= bus.D_in;
              bus.nWAIT     <= 1'b0;
            end else begin
              state     <= INTA;
              bus.D_out <= INT_VECTOR;
              bus.D_oe  <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack on the expiry edge wins, so no timeout pulse then.
          if (bus.rsp_ack || expire) begin
            state         <= DONE;
            bus.req_valid <= 1'b0;
            bus.nWAIT     <= 1'b1;
            bus.timeout   <= !bus.rsp_ack;
            if (!bus.req_write) begin
              bus.D_out <= bus.rsp_ack ? bus.rsp_rdata : 8'hFF;
              bus.D_oe  <= 1'b1;
            end
          end
        end
        INTA: begin
          state <= DONE;
        end
        DONE: begin
          if (strobesIdle) begin
            state    <= IDLE;
            bus.D_oe <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
